// File: rtl/cross_result_sampler.sv
// cross_result_sampler: synchronises an asynchronous result word into clk_ext, filters it for stability and queues each new stable value.
// Define CROSS_SAMPLER_PARITY_EN to store a parity bit per entry and expose it on out_parity.
module cross_result_sampler #(
    parameter int DATA_W     = 32,
    parameter int STABLE_CNT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_ext,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             din,
    input  logic                          sample_en,
    input  logic                          out_ready,
    input  logic                          clear_ovf,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
`ifdef CROSS_SAMPLER_PARITY_EN
    output logic                          out_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] s1, s2, s3, last_val;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [3:0]        cnt;
    logic              have_last;
    logic [LW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic              same, commit, pop, full, push, drop, head_vis;

    assign same       = s2 == s3;
    assign commit     = cnt == 4'(STABLE_CNT) && same && sample_en && (!have_last || s3 != last_val);
    assign pop        = out_valid && out_ready;
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = fifo_level == LW'(FIFO_DEPTH);
    assign push       = commit && (!full || pop);
    assign drop       = commit && full && !pop;
    assign rd_nxt     = rd_ptr + LW'(pop);
    // A push only becomes visible at the head one cycle later, so the head register compares against the current wr_ptr.
    assign head_vis   = wr_ptr != rd_nxt;

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            cnt       <= '0;
            last_val  <= '0;
            have_last <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            s1        <= din;
            s2        <= s1;
            s3        <= s2;
            cnt       <= !same ? 4'd0 : (cnt == 4'(STABLE_CNT) ? cnt : cnt + 4'd1);
            last_val  <= commit ? s3 : last_val;
            have_last <= have_last || commit;
            wr_ptr    <= wr_ptr + LW'(push);
            rd_ptr    <= rd_nxt;
            out_valid <= head_vis;
            out_data  <= mem[rd_nxt[AW-1:0]];
            overflow  <= drop || (overflow && !clear_ovf);
        end
    end

    always_ff @(posedge clk_ext) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s3;
    end

`ifdef CROSS_SAMPLER_PARITY_EN
    logic par [FIFO_DEPTH];

    always_ff @(posedge clk_ext) begin
        if (push) par[wr_ptr[AW-1:0]] <= ^s3;
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) out_parity <= 1'b0;
        else        out_parity <= head_vis && par[rd_nxt[AW-1:0]];
    end
`endif
endmodule
